matmul_engine: RTL and testbench
================================

Name: matmul_engine

Overview:
Parametrised successor to the coprocessor's fixed-size matrix-vector multiply unit. Computes RES[i] = post(sum over k of A[i][k]*B[k]) for runtime-configured M rows and N columns, up to compile-time maxima. Supports signed or unsigned operands and a selectable output stage: threshold, scaled-saturate or raw. Sits between the AXI-Stream wrapper FSM and the A/B/RES block RAMs; RAM reads are synchronous with 1-cycle latency.

Parameters:
WIDTH, 8, bits per RAM word and per operand.
A_DEPTH_BITS, 9, A RAM address bits.
B_DEPTH_BITS, 3, B RAM address bits.
RES_DEPTH_BITS, 6, RES RAM address bits.
MAX_M, 64, maximum rows; must be <= 2^RES_DEPTH_BITS.
MAX_N, 8, maximum columns; must be <= 2^B_DEPTH_BITS, and MAX_M*MAX_N <= 2^A_DEPTH_BITS.
ACC_WIDTH, 20, accumulator bits; must be >= 2*WIDTH+clog2(MAX_N). An elaboration-time check fails otherwise.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
Start  in  1  level request from wrapper; config sampled on the IDLE->RUN transition.
Done  out  1  job finished; held until Start is low.
Busy  out  1  high from job accept until Done rises.
Err  out  1  config invalid; valid while Done=1.
cfg_rows  in  RES_DEPTH_BITS+1  M, range 1..MAX_M.
cfg_cols  in  B_DEPTH_BITS+1  N, range 1..MAX_N.
cfg_signed  in  1  1 = two's-complement operands.
cfg_mode  in  2  0 = threshold, 1 = scaled, 2/3 = raw.
cfg_threshold  in  ACC_WIDTH  threshold-mode compare value; signedness follows cfg_signed.
cfg_shift  in  5  scaled-mode right-shift amount.
A_read_en  out  1  A RAM read enable.
A_read_address  out  A_DEPTH_BITS  A RAM read address.
A_read_data_out  in  WIDTH  A RAM read data.
B_read_en  out  1  B RAM read enable.
B_read_address  out  B_DEPTH_BITS  B RAM read address.
B_read_data_out  in  WIDTH  B RAM read data.
RES_write_en  out  1  RES RAM write strobe.
RES_write_address  out  RES_DEPTH_BITS  RES RAM write address.
RES_write_data_in  out  WIDTH  RES RAM write data.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and the accumulator 0. Reset mid-job aborts immediately with no further RAM writes.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - Start=1 latches all cfg_* inputs and sets Busy=1.
  - If rows=0, rows>MAX_M, cols=0 or cols>MAX_N: go to DONE with Err=1 and perform no reads or writes.
  - Otherwise go to ISSUE with row=0, k=0, row_base=0.
- ISSUE:
  - Drive A_read_en=B_read_en=1, A_read_address=row_base+k, B_read_address=k.
  - A 1-cycle valid pipe tags the request; the returning data is accumulated the following cycle.
  - k increments each cycle; after k=cols-1 go to DRAIN.
  - The read enables are 0 in every other state.
- DRAIN: accumulate the last product, then go to WRITE.
- WRITE:
  - Pulse RES_write_en for 1 cycle with address=row and data=post(acc).
  - Clear acc, row_base += cols (no multiplier), k=0.
  - If row=rows-1, go to DONE; otherwise row++ and go to ISSUE.
- Per-row cost is cols+2 cycles. Latency from the Start-sampling edge to Done=1 is rows*(cols+2)+1 cycles.
- DONE:
  - Done=1, Busy=0.
  - When Start=0, go to IDLE, clear Done and Err.
  - Start still high does not relaunch a job.
- Arithmetic:
  - Products are WIDTH x WIDTH, sign- or zero-extended per cfg_signed, then accumulated in ACC_WIDTH bits with no overflow possible.
- post() function:
  - Threshold mode: 1 if acc >= threshold (signed compare when signed), else 0.
  - Scaled mode: arithmetic shift right (logical when unsigned), then saturate to 0..2^WIDTH-1 or -2^(WIDTH-1)..2^(WIDTH-1)-1.
  - Raw mode: acc[WIDTH-1:0].
- cfg_* changes while Busy=1 are ignored.

Decomposition:
- matmul_pkg holds the state encoding, MODE_THRESH/MODE_SCALED/MODE_RAW constants, and the post() saturate/threshold function.
- One sub-module, matmul_mac: signed/unsigned multiply-accumulate with synchronous clear and a valid input, so it can map to a DSP slice.

Test Plan:
1. Unsigned raw mode, M=2, N=3, A=[1,2,3;4,5,6], B=[1,1,2] -> RES[0]=9, RES[1]=21; Done rises 11 cycles after Start is sampled; exactly 2 write pulses.
2. Threshold mode, M=64, N=8, every A=B=255, threshold=33000 -> all 64 RES=1; with threshold=520201 -> all 64 RES=0.
3. Signed scaled mode, shift=2, N=2, A=[-128,-128], B=[127,127] -> acc=-32512 -> -8128 -> saturates to -128; A=[2,3], B=[4,5] -> 23>>2 = 5.
4. cfg_cols=0 or cfg_cols=9 (MAX_N=8) -> Done with Err=1, read enables never asserted, no RES writes.
5. Reset asserted during row 3 of an M=10 job -> all outputs 0 on the same edge; a fresh Start then completes correctly.
6. Start held high through DONE -> Done stays 1 and no second job runs; dropping Start returns the block to IDLE the next cycle with Done=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types, output-mode codes and the result post-processing function
// for the matrix-vector multiply engine.
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_THRESH   = 2'd0;
  localparam logic [1:0] MODE_SCALED   = 2'd1;
  localparam logic [1:0] MODE_RAW      = 2'd2;
  localparam logic [1:0] MODE_RAW_ALT  = 2'd3;

  localparam int unsigned POST_W = 64;

  // acc and thr arrive already sign- or zero-extended to POST_W, so a single
  // signed compare/shift serves both operand types.
  function automatic logic [POST_W-1:0] post(
    input logic signed [POST_W-1:0] acc,
    input logic signed [POST_W-1:0] thr,
    input logic                     is_signed,
    input logic [1:0]               mode,
    input logic [4:0]               shift,
    input int unsigned              width
  );
    logic signed [POST_W-1:0] shifted;
    logic signed [POST_W-1:0] hi;
    logic signed [POST_W-1:0] lo;
    logic signed [POST_W-1:0] res;
    hi      = is_signed ? (64'sd1 <<< (width - 1)) - 64'sd1 : (64'sd1 <<< width) - 64'sd1;
    lo      = is_signed ? -(64'sd1 <<< (width - 1)) : 64'sd0;
    shifted = acc >>> shift;
    res     = acc;
    case (mode)
      MODE_THRESH: res = (acc >= thr) ? 64'sd1 : 64'sd0;
      MODE_SCALED: begin
        if (shifted > hi)      res = hi;
        else if (shifted < lo) res = lo;
        else                   res = shifted;
      end
      MODE_RAW, MODE_RAW_ALT: res = acc;
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed/unsigned multiply-accumulate with synchronous clear and valid input.
module matmul_mac #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 vld,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [ACC_WIDTH-1:0] acc
);

  logic signed [WIDTH:0]     a_x;
  logic signed [WIDTH:0]     b_x;
  logic signed [2*WIDTH+1:0] prod;

  // One extra bit lets a single signed multiplier cover both operand types.
  assign a_x  = {is_signed & a[WIDTH-1], a};
  assign b_x  = {is_signed & b[WIDTH-1], b};
  assign prod = a_x * b_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (vld) acc <= acc + ACC_WIDTH'(prod);
  end

endmodule

// File: rtl/matmul_engine.sv
// Runtime-sized matrix-vector multiply: streams A rows and B from block RAM,
// accumulates each row and writes the post-processed result to RES RAM.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned A_DEPTH_BITS   = 9,
  parameter int unsigned B_DEPTH_BITS   = 3,
  parameter int unsigned RES_DEPTH_BITS = 6,
  parameter int unsigned MAX_M          = 64,
  parameter int unsigned MAX_N          = 8,
  parameter int unsigned ACC_WIDTH      = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Start,
  output logic                      Done,
  output logic                      Busy,
  output logic                      Err,
  input  logic [RES_DEPTH_BITS:0]   cfg_rows,
  input  logic [B_DEPTH_BITS:0]     cfg_cols,
  input  logic                      cfg_signed,
  input  logic [1:0]                cfg_mode,
  input  logic [ACC_WIDTH-1:0]      cfg_threshold,
  input  logic [4:0]                cfg_shift,
  output logic                      A_read_en,
  output logic [A_DEPTH_BITS-1:0]   A_read_address,
  input  logic [WIDTH-1:0]          A_read_data_out,
  output logic                      B_read_en,
  output logic [B_DEPTH_BITS-1:0]   B_read_address,
  input  logic [WIDTH-1:0]          B_read_data_out,
  output logic                      RES_write_en,
  output logic [RES_DEPTH_BITS-1:0] RES_write_address,
  output logic [WIDTH-1:0]          RES_write_data_in
);

  if ((ACC_WIDTH < 2 * WIDTH + $clog2(MAX_N)) || (ACC_WIDTH >= POST_W) ||
      (MAX_M > (1 << RES_DEPTH_BITS)) || (MAX_N > (1 << B_DEPTH_BITS)) ||
      (MAX_M * MAX_N > (1 << A_DEPTH_BITS))) begin : g_param_check
    $error("matmul_engine: inconsistent WIDTH/ACC_WIDTH/MAX_M/MAX_N/depth parameters");
  end

  state_t                    state_q, state_d;
  logic [RES_DEPTH_BITS:0]   rows_q, rows_d;
  logic [B_DEPTH_BITS:0]     cols_q, cols_d;
  logic                      signed_q, signed_d;
  logic [1:0]                mode_q, mode_d;
  logic [ACC_WIDTH-1:0]      thr_q, thr_d;
  logic [4:0]                shift_q, shift_d;
  logic [RES_DEPTH_BITS-1:0] row_q, row_d;
  logic [B_DEPTH_BITS-1:0]   k_q, k_d;
  logic [A_DEPTH_BITS-1:0]   row_base_q, row_base_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      vld_q;
  logic                      acc_clr;
  logic [ACC_WIDTH-1:0]      acc;
  logic signed [POST_W-1:0]  acc_ext;
  logic signed [POST_W-1:0]  thr_ext;
  logic                      cfg_bad;
  logic                      k_last;
  logic                      row_last;

  matmul_mac #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .rst       (reset),
    .clr       (acc_clr),
    .vld       (vld_q),
    .is_signed (signed_q),
    .a         (A_read_data_out),
    .b         (B_read_data_out),
    .acc       (acc)
  );

  assign cfg_bad  = (cfg_rows == '0) || (cfg_rows > (RES_DEPTH_BITS + 1)'(MAX_M)) ||
                    (cfg_cols == '0) || (cfg_cols > (B_DEPTH_BITS + 1)'(MAX_N));
  assign k_last   = ({1'b0, k_q} == cols_q - (B_DEPTH_BITS + 1)'(1));
  assign row_last = ({1'b0, row_q} == rows_q - (RES_DEPTH_BITS + 1)'(1));

  always_comb begin
    acc_ext = signed_q ? {{(POST_W - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc}
                       : {{(POST_W - ACC_WIDTH){1'b0}}, acc};
    thr_ext = signed_q ? {{(POST_W - ACC_WIDTH){thr_q[ACC_WIDTH-1]}}, thr_q}
                       : {{(POST_W - ACC_WIDTH){1'b0}}, thr_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      signed_q   <= 1'b0;
      mode_q     <= '0;
      thr_q      <= '0;
      shift_q    <= '0;
      row_q      <= '0;
      k_q        <= '0;
      row_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      signed_q   <= signed_d;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      shift_q    <= shift_d;
      row_q      <= row_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_q      <= (state_q == S_ISSUE);
    end
  end

  always_comb begin
    state_d           = state_q;
    rows_d            = rows_q;
    cols_d            = cols_q;
    signed_d          = signed_q;
    mode_d            = mode_q;
    thr_d             = thr_q;
    shift_d           = shift_q;
    row_d             = row_q;
    k_d               = k_q;
    row_base_d        = row_base_q;
    busy_d            = busy_q;
    done_d            = done_q;
    err_d             = err_q;
    acc_clr           = 1'b0;
    A_read_en         = 1'b0;
    A_read_address    = '0;
    B_read_en         = 1'b0;
    B_read_address    = '0;
    RES_write_en      = 1'b0;
    RES_write_address = '0;
    RES_write_data_in = '0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          rows_d   = cfg_rows;
          cols_d   = cfg_cols;
          signed_d = cfg_signed;
          mode_d   = cfg_mode;
          thr_d    = cfg_threshold;
          shift_d  = cfg_shift;
          busy_d   = 1'b1;
          if (cfg_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            row_d      = '0;
            k_d        = '0;
            row_base_d = '0;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        A_read_en      = 1'b1;
        B_read_en      = 1'b1;
        A_read_address = row_base_q + A_DEPTH_BITS'(k_q);
        B_read_address = k_q;
        if (k_last) state_d = S_DRAIN;
        else        k_d     = k_q + 1'b1;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        RES_write_en      = 1'b1;
        RES_write_address = row_q;
        RES_write_data_in = WIDTH'(post(acc_ext, thr_ext, signed_q, mode_q, shift_q, WIDTH));
        acc_clr           = 1'b1;
        row_base_d        = row_base_q + A_DEPTH_BITS'(cols_q);
        k_d               = '0;
        if (row_last) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        // Done rises one cycle after entering DONE; only a low Start after that re-arms IDLE.
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (!Start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: directed table, hand-written corner
// sequences and randomized jobs against an integer reference model.
module tb_matmul_engine;

  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Done, Busy, Err;
  logic [6:0]  cfg_rows;
  logic [3:0]  cfg_cols;
  logic        cfg_signed;
  logic [1:0]  cfg_mode;
  logic [19:0] cfg_threshold;
  logic [4:0]  cfg_shift;
  logic        A_read_en, B_read_en, RES_write_en;
  logic [8:0]  A_read_address;
  logic [2:0]  B_read_address;
  logic [5:0]  RES_write_address;
  logic [7:0]  A_read_data_out, B_read_data_out, RES_write_data_in;

  logic [7:0]  a_mem [512];
  logic [7:0]  b_mem [8];
  logic [7:0]  res_mem [64];
  int          res_stamp [64];
  int          wr_total = 0;
  int          rd_total = 0;
  longint      exp_res [64];

  int n_cmp = 0;
  int n_bad = 0;

  matmul_engine dut (
    .clk               (clk),
    .reset             (reset),
    .Start             (Start),
    .Done              (Done),
    .Busy              (Busy),
    .Err               (Err),
    .cfg_rows          (cfg_rows),
    .cfg_cols          (cfg_cols),
    .cfg_signed        (cfg_signed),
    .cfg_mode          (cfg_mode),
    .cfg_threshold     (cfg_threshold),
    .cfg_shift         (cfg_shift),
    .A_read_en         (A_read_en),
    .A_read_address    (A_read_address),
    .A_read_data_out   (A_read_data_out),
    .B_read_en         (B_read_en),
    .B_read_address    (B_read_address),
    .B_read_data_out   (B_read_data_out),
    .RES_write_en      (RES_write_en),
    .RES_write_address (RES_write_address),
    .RES_write_data_in (RES_write_data_in)
  );

  always #5 clk = ~clk;

  // Block RAM models (1-cycle read latency) plus write/read activity log.
  always @(posedge clk) begin
    if (A_read_en) begin
      A_read_data_out <= a_mem[A_read_address];
      rd_total        <= rd_total + 1;
    end
    if (B_read_en) B_read_data_out <= b_mem[B_read_address];
    if (RES_write_en) begin
      res_mem[RES_write_address]   <= RES_write_data_in;
      res_stamp[RES_write_address] <= wr_total + 1;
      wr_total                     <= wr_total + 1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, longint'({Busy, Done, Err, A_read_en, B_read_en, RES_write_en,
                          A_read_address, B_read_address, RES_write_address,
                          RES_write_data_in}), 0);
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 512; i++) a_mem[i] = a;
    for (int i = 0; i < 8; i++)   b_mem[i] = b;
  endtask

  // Reference: plain integer dot products, then the output rule.
  task automatic model_job(input int rows, input int cols, input bit sgn,
                           input int mode, input longint thr, input int shift);
    longint acc, av, bv, s, hi, lo, v;
    hi = sgn ? 127 : 255;
    lo = sgn ? -128 : 0;
    for (int r = 0; r < rows; r++) begin
      acc = 0;
      for (int k = 0; k < cols; k++) begin
        av  = sgn ? longint'($signed(a_mem[r * cols + k])) : longint'(a_mem[r * cols + k]);
        bv  = sgn ? longint'($signed(b_mem[k])) : longint'(b_mem[k]);
        acc = acc + av * bv;
      end
      if (mode == 0) v = (acc >= thr) ? 1 : 0;
      else if (mode == 1) begin
        s = acc >>> shift;
        v = (s > hi) ? hi : (s < lo) ? lo : s;
      end else v = acc;
      exp_res[r] = v & 255;
    end
  endtask

  task automatic run_job(input string name, input int rows, input int cols, input bit sgn,
                         input int mode, input longint thr, input int shift,
                         input bit exp_err, input int hold);
    int  start_wr, start_rd, lat, wr_at_done;
    bit  seen;
    @(negedge clk);
    cfg_rows      = 7'(rows);
    cfg_cols      = 4'(cols);
    cfg_signed    = sgn;
    cfg_mode      = 2'(mode);
    cfg_threshold = 20'(thr);
    cfg_shift     = 5'(shift);
    Start         = 1'b1;
    start_wr      = wr_total;
    start_rd      = rd_total;
    @(posedge clk);
    #1;
    check({name, " busy_after_accept"}, Busy, 1);
    cfg_rows      = 7'($urandom);
    cfg_cols      = 4'($urandom);
    cfg_signed    = 1'($urandom);
    cfg_mode      = 2'($urandom);
    cfg_threshold = 20'($urandom);
    cfg_shift     = 5'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (Done) begin
        lat  = n;
        seen = 1'b1;
        break;
      end
    end
    check({name, " done_seen"}, seen, 1);
    if (!exp_err) check({name, " latency"}, lat, rows * (cols + 2) + 1);
    check({name, " err"}, Err, exp_err);
    check({name, " busy_at_done"}, Busy, 0);
    check({name, " writes"}, wr_total - start_wr, exp_err ? 0 : rows);
    check({name, " reads"}, rd_total - start_rd, exp_err ? 0 : rows * cols);
    if (!exp_err) begin
      for (int r = 0; r < rows; r++) begin
        check($sformatf("%s row%0d written", name, r), res_stamp[r] > start_wr, 1);
        check($sformatf("%s row%0d data", name, r), res_mem[r], exp_res[r]);
      end
    end
    wr_at_done = wr_total;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({name, " done_held"}, Done, 1);
      check({name, " no_relaunch"}, wr_total - wr_at_done, 0);
      check({name, " busy_held_low"}, Busy, 0);
    end
    @(negedge clk);
    Start = 1'b0;
    @(posedge clk);
    #1;
    check({name, " done_cleared"}, Done, 0);
    check({name, " err_cleared"}, Err, 0);
  endtask

  typedef struct {
    int         rows;
    int         cols;
    bit         sgn;
    int         mode;
    longint     thr;
    int         shift;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    bit         err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     s_wr, s_rd, rows, cols, mode, shift;
    bit     sgn, reached;
    longint thr;

    reset = 1'b1; Start = 1'b0;
    cfg_rows = '0; cfg_cols = '0; cfg_signed = 1'b0; cfg_mode = '0;
    cfg_threshold = '0; cfg_shift = '0;
    fill_const(8'd0, 8'd0);
    for (int i = 0; i < 64; i++) begin res_mem[i] = '0; res_stamp[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    reset = 1'b0;

    //          rows cols sgn mode thr     sh  a      b      exp    err
    tbl[0]  = '{64,  8,   0,  0,   33000,  0,  8'hFF, 8'hFF, 8'd1,  0};
    tbl[1]  = '{64,  8,   0,  0,   520201, 0,  8'hFF, 8'hFF, 8'd0,  0};
    tbl[2]  = '{2,   2,   1,  1,   0,      2,  8'h80, 8'h7F, 8'h80, 0};
    tbl[3]  = '{3,   0,   0,  2,   0,      0,  8'h01, 8'h01, 8'd0,  1};
    tbl[4]  = '{3,   9,   0,  2,   0,      0,  8'h01, 8'h01, 8'd0,  1};
    tbl[5]  = '{0,   4,   0,  2,   0,      0,  8'h01, 8'h01, 8'd0,  1};
    tbl[6]  = '{65,  1,   0,  2,   0,      0,  8'h01, 8'h01, 8'd0,  1};
    tbl[7]  = '{1,   8,   0,  2,   0,      0,  8'hFF, 8'hFF, 8'd8,  0};
    tbl[8]  = '{4,   1,   0,  1,   0,      3,  8'd10, 8'd10, 8'd12, 0};
    tbl[9]  = '{3,   4,   1,  0,   -5,     0,  8'hFF, 8'h01, 8'd1,  0};
    tbl[10] = '{2,   4,   1,  0,   -3,     0,  8'hFF, 8'h01, 8'd0,  0};
    tbl[11] = '{1,   2,   0,  1,   0,      0,  8'hFF, 8'hFF, 8'hFF, 0};
    tbl[12] = '{1,   2,   1,  1,   0,      1,  8'h7F, 8'h7F, 8'h7F, 0};
    tbl[13] = '{1,   2,   1,  3,   0,      0,  8'hFD, 8'h05, 8'd226, 0};
    tbl[14] = '{1,   1,   0,  0,   100,    0,  8'd10, 8'd10, 8'd1,  0};

    for (int i = 0; i < 15; i++) begin
      fill_const(tbl[i].a, tbl[i].b);
      for (int r = 0; r < 64; r++) exp_res[r] = longint'(tbl[i].exp);
      run_job($sformatf("vec%0d", i), tbl[i].rows, tbl[i].cols, tbl[i].sgn, tbl[i].mode,
              tbl[i].thr, tbl[i].shift, tbl[i].err, 0);
    end

    // Unsigned raw 2x3 job, with Start held high through DONE.
    fill_const(8'd0, 8'd0);
    a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[2] = 8'd3;
    a_mem[3] = 8'd4; a_mem[4] = 8'd5; a_mem[5] = 8'd6;
    b_mem[0] = 8'd1; b_mem[1] = 8'd1; b_mem[2] = 8'd2;
    exp_res[0] = 9; exp_res[1] = 21;
    run_job("raw_2x3_hold", 2, 3, 1'b0, 2, 0, 0, 1'b0, 6);

    // Signed scaled, small positive sum.
    fill_const(8'd0, 8'd0);
    a_mem[0] = 8'd2; a_mem[1] = 8'd3;
    b_mem[0] = 8'd4; b_mem[1] = 8'd5;
    exp_res[0] = 5;
    run_job("scaled_23", 1, 2, 1'b1, 1, 0, 2, 1'b0, 0);

    // Reset during row 3 of a 10-row job, then a fresh job.
    for (int i = 0; i < 512; i++) a_mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++)   b_mem[i] = 8'($urandom);
    @(negedge clk);
    cfg_rows = 7'd10; cfg_cols = 4'd3; cfg_signed = 1'b0; cfg_mode = 2'd2;
    cfg_threshold = '0; cfg_shift = '0;
    s_wr  = wr_total;
    Start = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk);
      if (wr_total - s_wr >= 3) begin reached = 1'b1; break; end
    end
    check("midjob_row3_reached", reached, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midjob_reset_outputs");
    Start = 1'b0;
    s_wr  = wr_total;
    s_rd  = rd_total;
    repeat (4) @(posedge clk);
    #1;
    check("midjob_no_writes_after_reset", wr_total - s_wr, 0);
    check("midjob_no_reads_after_reset", rd_total - s_rd, 0);
    @(negedge clk);
    reset = 1'b0;
    model_job(10, 3, 1'b0, 2, 0, 0);
    run_job("after_reset", 10, 3, 1'b0, 2, 0, 0, 1'b0, 0);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 10; j++) begin
      rows  = int'($urandom_range(1, 12));
      cols  = int'($urandom_range(1, 8));
      sgn   = 1'($urandom);
      mode  = int'($urandom_range(0, 3));
      shift = int'($urandom_range(0, 12));
      thr   = sgn ? longint'($urandom_range(0, 4000)) - 2000 : longint'($urandom_range(0, 6000));
      for (int i = 0; i < rows * cols; i++) a_mem[i] = 8'($urandom);
      for (int i = 0; i < cols; i++)        b_mem[i] = 8'($urandom);
      model_job(rows, cols, sgn, mode, thr, shift);
      run_job($sformatf("rand%0d", j), rows, cols, sgn, mode, thr, shift, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
